pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Receiving end of the execute stage's control interface (jump_addr/jump_en/hold_flag).
- Owns the program counter and drives fetch.
- Issues pipeline flushes for the IF/ID and ID/EX registers on a taken jump.
- Buffers a jump target when fetch is stalled by the instruction bus, and applies it once the stall releases.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; first fetch address.
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- jump_addr_i  input  32  branch/jump target from execute
- jump_en_i  input  1  taken jump/branch from execute (combinational, same-cycle)
- hold_flag_i  input  1  pipeline hold request from execute
- bus_hold_i  input  1  instruction bus busy; fetch address must not change
- pc_o  output  32  current fetch address (registered)
- pc_valid_o  output  1  pc_o is a legal fetch address (registered)
- hold_pc_o  output  1  PC not advancing this cycle (combinational)
- flush_if_id_o  output  1  kill IF/ID register content (combinational)
- flush_id_ex_o  output  1  kill ID/EX register content (combinational)
- misalign_o  output  1  jump target bits[1:0] nonzero (combinational)
- redirect_cnt_o  output  CNT_W  saturating count of accepted redirects (registered)

Behaviour:
- Reset (async, any time, including in PENDING):
  - pc_o=RESET_ADDR, pc_valid_o=0, redirect_cnt_o=0, pending_addr=0, state=BOOT.
  - Combinational outputs follow from state BOOT: hold_pc_o=1, flushes 0.
- States: BOOT, RUN, PENDING (2-bit encoding).
- BOOT:
  - Lasts exactly one clock after rst deasserts; all inputs are ignored.
  - On that edge: pc_valid_o<=1, pc_o stays RESET_ADDR, state->RUN.
- RUN, priority jump > hold > advance:
  - jump_en_i=1, bus_hold_i=0:
    - pc_o<={jump_addr_i[31:2],2'b00}; redirect_cnt_o++; stay RUN.
    - flush_if_id_o=flush_id_ex_o=1 in the same cycle as jump_en_i.
  - jump_en_i=1, bus_hold_i=1:
    - pending_addr<={jump_addr_i[31:2],2'b00}; pc_o held; redirect_cnt_o++; state->PENDING.
    - Both flushes=1 this cycle.
  - jump_en_i=0 with hold_flag_i|bus_hold_i: pc_o held, hold_pc_o=1, no flush.
  - Otherwise: pc_o<=pc_o+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- PENDING:
  - pc_o held; hold_pc_o=1; flush_if_id_o=1 every cycle (wrong-path fetch); flush_id_ex_o=0 unless jump_en_i.
  - bus_hold_i=0: pc_o<=pending_addr, state->RUN. hold_flag_i is ignored for this transfer.
  - jump_en_i=1 (should not occur; handled defensively):
    - pending_addr is overwritten with the new target (same cycle as the exit if bus_hold_i=0; new target wins).
    - flush_id_ex_o=1; redirect_cnt_o++.
- hold_pc_o = BOOT | PENDING | (RUN & ~(jump_en_i&~bus_hold_i) & (hold_flag_i|bus_hold_i)).
  - A jump with bus_hold_i=1 counts as a hold.
- misalign_o = jump_en_i & |jump_addr_i[1:0], in any state except BOOT. Target low bits are forced to 00 regardless.
- redirect_cnt_o saturates at all-ones; no wrap.
- pc_valid_o stays 1 until the next reset.
- Implementation: single always block for state/PC (async rst in sensitivity list), separate combinational block for flush/hold outputs; no latches.

Test Plan:
- Reset release, RESET_ADDR=32'h100 -> cycle0 pc_o=100 valid=0; cycle1 valid=1 pc=100; then 104, 108, 10C on successive edges.
- At pc=108, assert jump_en_i with jump_addr_i=32'h200 for 1 cycle -> both flushes=1 that cycle; next pc_o=200, then 204; redirect_cnt_o=1.
- hold_flag_i=1 for 3 cycles at pc=204 -> pc_o stays 204, hold_pc_o=1, no flush; resumes 208.
- bus_hold_i=1 while jump_en_i=1 to 32'h300, bus_hold held 4 more cycles -> pc_o frozen, flush_if_id_o=1 all 5 cycles; one edge after bus_hold_i falls, pc_o=300, state RUN.
- jump_en_i+hold_flag_i together to 32'h402 -> misalign_o=1; pc_o=400 (jump wins, low bits cleared).
- pc_o=FFFF_FFFC advancing -> pc_o=0. Assert rst mid-PENDING -> pc_o=RESET_ADDR and valid=0 immediately (before next clk edge); pending target discarded after release.

Source files
------------

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
//   Program-counter owner for the fetch stage. It takes the execute stage's
//   control interface (jump target, jump enable, pipeline hold) and produces
//   the fetch address. A taken jump flushes the IF/ID and ID/EX registers. If
//   the instruction bus is busy when a jump is taken, the target is parked in
//   a pending register and applied once the bus releases.
//
// Parameters
//   RESET_ADDR : PC loaded on reset; this is the first fetch address
//   CNT_W      : width of the saturating taken-redirect counter
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   jump_addr_i    in   jump/branch target from execute
//   jump_en_i      in   taken jump/branch from execute (same cycle)
//   hold_flag_i    in   pipeline hold request from execute
//   bus_hold_i     in   instruction bus busy; fetch address must not move
//   pc_o           out  current fetch address (registered)
//   pc_valid_o     out  pc_o is a legal fetch address (registered)
//   hold_pc_o      out  PC is not advancing this cycle (combinational)
//   flush_if_id_o  out  kill IF/ID register content (combinational)
//   flush_id_ex_o  out  kill ID/EX register content (combinational)
//   misalign_o     out  jump target low bits nonzero (combinational)
//   redirect_cnt_o out  saturating count of accepted redirects (registered)
// -----------------------------------------------------------------------------
module pc_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      jump_addr_i,
  input  logic             jump_en_i,
  input  logic             hold_flag_i,
  input  logic             bus_hold_i,
  output logic [31:0]      pc_o,
  output logic             pc_valid_o,
  output logic             hold_pc_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PENDING = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_pc;
  logic             r_pc_valid;
  logic [31:0]      r_pending_addr;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic [31:0]      w_target;
  logic             w_in_run;
  logic             w_in_pending;
  logic             w_cnt_full;

  // Targets are always word aligned; misaligned low bits are reported, then dropped.
  assign w_target     = {jump_addr_i[31:2], 2'b00};
  assign w_in_run     = (r_state == S_RUN);
  assign w_in_pending = (r_state == S_PENDING);
  assign w_cnt_full   = &r_redirect_cnt;

  // State, PC, pending target and redirect counter.
  // NOTE: sequential state uses non-blocking assignments only so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_BOOT;
      r_pc           <= RESET_ADDR;
      r_pc_valid     <= 1'b0;
      r_pending_addr <= 32'h0;
      r_redirect_cnt <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          // One settling cycle after reset; inputs are ignored.
          r_pc_valid <= 1'b1;
          r_state    <= S_RUN;
        end

        S_RUN: begin
          if (jump_en_i) begin
            if (!w_cnt_full) r_redirect_cnt <= r_redirect_cnt + 1'b1;
            if (bus_hold_i) begin
              r_pending_addr <= w_target;
              r_state        <= S_PENDING;
            end else begin
              r_pc <= w_target;
            end
          end else if (!(hold_flag_i || bus_hold_i)) begin
            r_pc <= r_pc + 32'd4;
          end
        end

        S_PENDING: begin
          // A jump here should not happen; if it does the newest target wins.
          if (jump_en_i) begin
            if (!w_cnt_full) r_redirect_cnt <= r_redirect_cnt + 1'b1;
            r_pending_addr <= w_target;
          end
          // hold_flag_i deliberately does not delay the parked redirect.
          if (!bus_hold_i) begin
            r_pc    <= jump_en_i ? w_target : r_pending_addr;
            r_state <= S_RUN;
          end
        end

        default: r_state <= S_BOOT;
      endcase
    end
  end

  // Hold and flush controls.
  // NOTE: every output gets a default before the conditions so no latch is inferred.
  always_comb begin
    hold_pc_o     = 1'b1;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    misalign_o    = 1'b0;
    if (w_in_run) begin
      // A jump stalled by the bus still counts as a hold.
      hold_pc_o     = ~(jump_en_i & ~bus_hold_i) & (hold_flag_i | bus_hold_i);
      flush_if_id_o = jump_en_i;
      flush_id_ex_o = jump_en_i;
      misalign_o    = jump_en_i & (|jump_addr_i[1:0]);
    end else if (w_in_pending) begin
      // Whatever fetch returns while the redirect is parked is wrong-path.
      hold_pc_o     = 1'b1;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = jump_en_i;
      misalign_o    = jump_en_i & (|jump_addr_i[1:0]);
    end
  end

  assign pc_o           = r_pc;
  assign pc_valid_o     = r_pc_valid;
  assign redirect_cnt_o = r_redirect_cnt;

endmodule

// File: tb/tb_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ctrl
//   Directed bench for pc_ctrl with RESET_ADDR = 32'h100. A second instance
//   with a 2-bit redirect counter shares the stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] jump_addr_i;
  logic        jump_en_i;
  logic        hold_flag_i;
  logic        bus_hold_i;

  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        hold_pc_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        misalign_o;
  logic [15:0] redirect_cnt_o;

  logic [31:0] s_pc_o;
  logic        s_pc_valid_o;
  logic        s_hold_pc_o;
  logic        s_flush_if_id_o;
  logic        s_flush_id_ex_o;
  logic        s_misalign_o;
  logic [1:0]  s_redirect_cnt_o;

  int tests;
  int fails;

  pc_ctrl #(.RESET_ADDR(32'h100), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_addr_i    (jump_addr_i),
    .jump_en_i      (jump_en_i),
    .hold_flag_i    (hold_flag_i),
    .bus_hold_i     (bus_hold_i),
    .pc_o           (pc_o),
    .pc_valid_o     (pc_valid_o),
    .hold_pc_o      (hold_pc_o),
    .flush_if_id_o  (flush_if_id_o),
    .flush_id_ex_o  (flush_id_ex_o),
    .misalign_o     (misalign_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  pc_ctrl #(.RESET_ADDR(32'h100), .CNT_W(2)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .jump_addr_i    (jump_addr_i),
    .jump_en_i      (jump_en_i),
    .hold_flag_i    (hold_flag_i),
    .bus_hold_i     (bus_hold_i),
    .pc_o           (s_pc_o),
    .pc_valid_o     (s_pc_valid_o),
    .hold_pc_o      (s_hold_pc_o),
    .flush_if_id_o  (s_flush_if_id_o),
    .flush_id_ex_o  (s_flush_id_ex_o),
    .misalign_o     (s_misalign_o),
    .redirect_cnt_o (s_redirect_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control outputs: hold, flush IF/ID, flush ID/EX.
  task automatic check_ctl(input string tag, input logic h, input logic fi, input logic fe);
    check({tag, ".hold"},     {31'b0, hold_pc_o},     {31'b0, h});
    check({tag, ".flush_if"}, {31'b0, flush_if_id_o}, {31'b0, fi});
    check({tag, ".flush_ex"}, {31'b0, flush_id_ex_o}, {31'b0, fe});
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    jump_addr_i = 32'h0;
    jump_en_i   = 1'b0;
    hold_flag_i = 1'b0;
    bus_hold_i  = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst.pc",    pc_o,                    32'h100);
    check("rst.valid", {31'b0, pc_valid_o},     32'h0);
    check("rst.cnt",   {16'b0, redirect_cnt_o}, 32'h0);
    check_ctl("rst", 1'b1, 1'b0, 1'b0);
    // Jump inputs are ignored while booting.
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0003;
    #1;
    check("boot.misalign", {31'b0, misalign_o}, 32'h0);
    check_ctl("boot.jump", 1'b1, 1'b0, 1'b0);
    jump_en_i   = 1'b0;
    jump_addr_i = 32'h0;

    // ---------------- boot and sequential fetch ----------------
    rst = 1'b0;
    #1;
    check("c0.pc",    pc_o,                32'h100);
    check("c0.valid", {31'b0, pc_valid_o}, 32'h0);
    tick();
    check("c1.pc",    pc_o,                32'h100);
    check("c1.valid", {31'b0, pc_valid_o}, 32'h1);
    check_ctl("c1", 1'b0, 1'b0, 1'b0);
    tick();
    check("seq.104", pc_o, 32'h104);
    tick();
    check("seq.108", pc_o, 32'h108);

    // ---------------- taken jump ----------------
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h200;
    #1;
    check_ctl("jmp", 1'b0, 1'b1, 1'b1);
    check("jmp.misalign", {31'b0, misalign_o}, 32'h0);
    tick();
    jump_en_i = 1'b0;
    #1;
    check("jmp.pc",  pc_o,                    32'h200);
    check("jmp.cnt", {16'b0, redirect_cnt_o}, 32'h1);
    check_ctl("jmp.after", 1'b0, 1'b0, 1'b0);
    tick();
    check("jmp.204", pc_o, 32'h204);

    // ---------------- pipeline hold ----------------
    hold_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ctl("hold", 1'b1, 1'b0, 1'b0);
      tick();
      check("hold.pc", pc_o, 32'h204);
    end
    hold_flag_i = 1'b0;
    tick();
    check("hold.resume", pc_o, 32'h208);

    // ---------------- jump under bus hold ----------------
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h300;
    bus_hold_i  = 1'b1;
    #1;
    check_ctl("bjmp", 1'b1, 1'b1, 1'b1);
    tick();
    jump_en_i = 1'b0;
    check("bjmp.pc",  pc_o,                    32'h208);
    check("bjmp.cnt", {16'b0, redirect_cnt_o}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_ctl("pend", 1'b1, 1'b1, 1'b0);
      tick();
      check("pend.pc", pc_o, 32'h208);
    end
    bus_hold_i  = 1'b0;
    hold_flag_i = 1'b1;  // ignored for the parked transfer
    #1;
    check_ctl("pend.exit", 1'b1, 1'b1, 1'b0);
    tick();
    hold_flag_i = 1'b0;
    #1;
    check("pend.target", pc_o, 32'h300);
    check_ctl("pend.run", 1'b0, 1'b0, 1'b0);

    // ---------------- jump beats hold, misaligned target ----------------
    jump_en_i   = 1'b1;
    hold_flag_i = 1'b1;
    jump_addr_i = 32'h402;
    #1;
    check("mis.flag", {31'b0, misalign_o}, 32'h1);
    check_ctl("mis", 1'b0, 1'b1, 1'b1);
    tick();
    jump_en_i   = 1'b0;
    hold_flag_i = 1'b0;
    check("mis.pc",  pc_o,                    32'h400);
    check("mis.cnt", {16'b0, redirect_cnt_o}, 32'h3);

    // ---------------- wrap at top of address space ----------------
    jump_en_i   = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_en_i = 1'b0;
    check("wrap.top",  pc_o,                      32'hFFFF_FFFC);
    check("sat.cnt4",  {30'b0, s_redirect_cnt_o}, 32'h3);
    tick();
    check("wrap.zero", pc_o, 32'h0);

    // ---------------- jump while pending, exit same cycle ----------------
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h500;
    bus_hold_i  = 1'b1;
    tick();
    check("pj.hold_pc", pc_o, 32'h0);
    jump_addr_i = 32'h604;
    bus_hold_i  = 1'b0;
    #1;
    check_ctl("pj", 1'b1, 1'b1, 1'b1);
    tick();
    jump_en_i = 1'b0;
    check("pj.pc",  pc_o,                      32'h604);
    check("pj.cnt", {16'b0, redirect_cnt_o},   32'h6);
    check("sat.cnt6", {30'b0, s_redirect_cnt_o}, 32'h3);

    // ---------------- reset asserted mid-pending ----------------
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h700;
    bus_hold_i  = 1'b1;
    tick();
    jump_en_i = 1'b0;
    check("rp.pc", pc_o, 32'h604);
    #2;
    rst = 1'b1;
    #1;
    check("rp.async_pc",    pc_o,                    32'h100);
    check("rp.async_valid", {31'b0, pc_valid_o},     32'h0);
    check("rp.async_cnt",   {16'b0, redirect_cnt_o}, 32'h0);
    check_ctl("rp.async", 1'b1, 1'b0, 1'b0);
    bus_hold_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rp.boot_pc",    pc_o,                32'h100);
    check("rp.boot_valid", {31'b0, pc_valid_o}, 32'h1);
    tick();
    check("rp.no_pending", pc_o, 32'h104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
